// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// Module : fetch_unit_pkg
// Brief  : Shared state encoding, reset/NOP constants and opcode decode for
//          the instruction fetch unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] C_NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

    localparam logic [6:0] C_OP_LUI    = 7'b0110111;
    localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] C_OP_JAL    = 7'b1101111;
    localparam logic [6:0] C_OP_JALR   = 7'b1100111;
    localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OP_STORE  = 7'b0100011;
    localparam logic [6:0] C_OP_IMM    = 7'b0010011;
    localparam logic [6:0] C_OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {
        OPC_ALU    = 3'd0,
        OPC_LOAD   = 3'd1,
        OPC_STORE  = 3'd2,
        OPC_BRANCH = 3'd3,
        OPC_JUMP   = 3'd4,
        OPC_UPPER  = 3'd5,
        OPC_OTHER  = 3'd6
    } op_class_e;

    // Coarse opcode class consumed by the downstream type decoder.
    function automatic op_class_e op_class(input logic [6:0] op);
        case (op)
            C_OP_IMM, C_OP_REG:   return OPC_ALU;
            C_OP_LOAD:            return OPC_LOAD;
            C_OP_STORE:           return OPC_STORE;
            C_OP_BRANCH:          return OPC_BRANCH;
            C_OP_JAL, C_OP_JALR:  return OPC_JUMP;
            C_OP_LUI, C_OP_AUIPC: return OPC_UPPER;
            default:              return OPC_OTHER;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_pc_reg.sv
// ============================================================================
// Module : fetch_pc_reg
// Brief  : Program counter register with +4 increment and redirect mux.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_redirect,
    input  logic [31:0] i_target,
    input  logic        i_advance,
    output logic [31:0] o_pc
);

    logic [31:0] r_pc;

    // Redirect wins over sequential advance; the add wraps modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_redirect) begin
            r_pc <= i_target;
        end else if (i_advance) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    assign o_pc = r_pc;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module : fetch_unit
// Brief  : Single-outstanding instruction fetch FSM with IF/ID register and
//          skid buffer. FETCH_MISALIGN_CHK_EN enables misaligned-target trap.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = C_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [6:0]  id_op,
    output logic        fetch_err
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;

    logic        r_id_valid;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc;

    logic [31:0] w_pc;
    logic [31:0] w_target;
    logic        w_halt;
    logic        w_free;
    logic        w_req_fire;
    logic        w_rsp_take;

`ifdef FETCH_MISALIGN_CHK_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            r_err <= 1'b1;
        end
    end

    assign w_target  = redirect_pc;
    assign w_halt    = r_err;
    assign fetch_err = r_err;
`else
    logic w_unused_lsb;

    assign w_unused_lsb = ^redirect_pc[1:0];
    assign w_target     = {redirect_pc[31:2], 2'b00};
    assign w_halt       = 1'b0;
    assign fetch_err    = 1'b0;
`endif

    assign w_free     = !r_id_valid || !stall;
    assign w_req_fire = imem_req_valid && imem_req_ready;
    assign w_rsp_take = (r_state == ST_WAIT) && imem_rsp_valid && !redirect_valid;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst        (rst),
        .i_redirect (redirect_valid),
        .i_target   (w_target),
        .i_advance  (w_rsp_take),
        .o_pc       (w_pc)
    );

    // A reset landing on an outstanding request must still swallow its response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= (r_state == ST_WAIT) ? ST_DROP : ST_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_REQ: begin
                // A request accepted in the redirect cycle is already stale.
                if (redirect_valid) begin
                    w_state_nxt = w_req_fire ? ST_DROP : ST_REQ;
                end else if (w_req_fire) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    w_state_nxt = (redirect_valid || w_free) ? ST_REQ : ST_HOLD;
                end else if (redirect_valid) begin
                    w_state_nxt = ST_DROP;
                end
            end
            ST_DROP: begin
                if (imem_rsp_valid) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (redirect_valid || !stall) begin
                    w_state_nxt = ST_REQ;
                end
            end
            default: w_state_nxt = ST_REQ;
        endcase
    end

    always_comb begin
        imem_req_valid = (r_state == ST_REQ) && !w_halt;
        imem_addr      = w_pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_valid   <= 1'b0;
            r_id_instr   <= C_NOP;
            r_id_pc      <= 32'h0000_0000;
            r_skid_instr <= 32'h0000_0000;
            r_skid_pc    <= 32'h0000_0000;
        end else begin
            if (redirect_valid) begin
                r_id_valid <= 1'b0;
            end else if (w_rsp_take && w_free) begin
                r_id_valid <= 1'b1;
                r_id_instr <= imem_rsp_data;
                r_id_pc    <= w_pc;
            end else if ((r_state == ST_HOLD) && !stall) begin
                r_id_valid <= 1'b1;
                r_id_instr <= r_skid_instr;
                r_id_pc    <= r_skid_pc;
            end else if (!stall) begin
                r_id_valid <= 1'b0;
            end

            if (w_rsp_take && !w_free) begin
                r_skid_instr <= imem_rsp_data;
                r_skid_pc    <= w_pc;
            end
        end
    end

    assign id_valid = r_id_valid;
    assign id_instr = r_id_instr;
    assign id_pc    = r_id_pc;
    assign id_op    = r_id_instr[6:0];

endmodule

`default_nettype wire
